fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 5 +
 rtl/fifo_rd_skid.sv | 53 +++++
 rtl/fifo_rd_stream.sv | 52 +++++
 tb/tb_fifo_rd_stream.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: output-buffer depth and occupancy encodings shared by the FIFO read stream.
package fifo_pkg;
   localparam int DEPTH = 2;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} cnt_e;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry output buffer with head/tail pointers and a registered head word.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rd,
   output cnt_e             count,
   output logic [DSIZE-1:0] head_data
);
   logic [DSIZE-1:0] mem [DEPTH];
   logic             head, tail;
   cnt_e             count_nx;
   logic [DSIZE-1:0] head_nx;

   // head_data is the word that will sit at the head after this edge
   always_comb begin
      count_nx = count;
      head_nx  = head_data;
      if (wr && !rd)
         count_nx = cnt_e'(count + 2'd1);
      else if (rd && !wr)
         count_nx = cnt_e'(count - 2'd1);
      if (rd)
         head_nx = (count == TWO) ? mem[~head] : wdata;
      else if (count == EMPTY)
         head_nx = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= EMPTY;
         head      <= 1'b0;
         tail      <= 1'b0;
         head_data <= '0;
         mem[0]    <= '0;
         mem[1]    <= '0;
      end else begin
         count     <= count_nx;
         head_data <= head_nx;
         if (wr) begin
            mem[tail] <= wdata;
            tail      <= ~tail;
         end
         if (rd)
            head <= ~head;
      end
   end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a FIFO pop interface into a valid/ready stream with credit-based
// popping so an in-flight word always has a free buffer slot.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int    DSIZE       = 8,
   parameter string FALLTHROUGH = "TRUE",
   parameter int    CNT_W       = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DSIZE-1:0] m_data,
   output logic [CNT_W-1:0] pop_count
);
   localparam bit FT = (FALLTHROUGH == "TRUE");

   cnt_e count;
   logic inflight, drain, capture;

   assign m_valid = (count != EMPTY);
   assign drain   = m_valid && m_ready;
   // count + inflight - drain < DEPTH, rearranged to avoid unsigned underflow
   assign rinc    = rrst_n && !rempty &&
                    (({1'b0, count} + {2'b0, inflight}) < (3'(DEPTH) + {2'b0, drain}));
   assign capture = FT ? rinc : inflight;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         inflight  <= 1'b0;
         pop_count <= '0;
      end else begin
         inflight <= !FT && rinc;
         if (drain)
            pop_count <= pop_count + CNT_W'(1);
      end
   end

   fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
      .clk      (rclk),
      .rst_n    (rrst_n),
      .wr       (capture),
      .wdata    (rdata),
      .rd       (drain),
      .count    (count),
      .head_data(m_data)
   );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives a fall-through and a registered-read instance from queue-based
// FIFO models and checks every cycle against a word-level buffer model.
module tb_fifo_rd_stream;
   logic        rclk = 1'b0, rrst_n = 1'b0, m_ready = 1'b0;
   logic        rempty [2] = '{1'b1, 1'b1};
   logic        gate [2] = '{1'b0, 1'b0};
   logic [7:0]  rdata [2] = '{8'h00, 8'h00};
   logic [7:0]  m_data [2];
   logic        rinc [2], m_valid [2];
   logic [15:0] pop_count [2];
   logic [7:0]  q [2][$];
   logic [7:0]  bq [2][$];
   logic [7:0]  fq [2][$];
   logic [15:0] pc [2] = '{16'h0, 16'h0};
   int          rinc_cnt [2] = '{0, 0};
   int          dcnt [2];
   int          checks = 0, errors = 0;
   bit          ev [2], dr [2], po [2];
   bit          er;
   logic [7:0]  w;

   always #5 rclk = ~rclk;

   fifo_rd_stream #(.DSIZE(8), .FALLTHROUGH("TRUE"), .CNT_W(16)) dut_t (
      .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[0]), .rdata(rdata[0]), .rinc(rinc[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]), .pop_count(pop_count[0]));
   fifo_rd_stream #(.DSIZE(8), .FALLTHROUGH("FALSE"), .CNT_W(16)) dut_f (
      .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[1]), .rdata(rdata[1]), .rinc(rinc[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]), .pop_count(pop_count[1]));

   assign dcnt[0] = int'(dut_t.count);
   assign dcnt[1] = int'(dut_f.count);

   task automatic chk(input string name, input int m, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s mode%0d: got %0h, expected %0h", name, m, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge rclk);
         #2;
      end
   endtask

   function automatic int pending();
      return q[0].size() + q[1].size() + bq[0].size() + bq[1].size() + fq[0].size() + fq[1].size();
   endfunction

   task automatic drain_wait(input string name);
      int c;
      c = 0;
      gate[1] = 1'b0;
      m_ready = 1'b1;
      while (c < 200 && pending() != 0) begin
         cyc(1);
         c++;
      end
      chk(name, 0, int'(pending() == 0), 1);
   endtask

   // model: mode 0 captures on the pop edge, mode 1 one edge later via fq
   always begin
      @(negedge rclk);
      for (int m = 0; m < 2; m++) begin
         if (!rrst_n) begin
            bq[m].delete();
            fq[m].delete();
            pc[m] = '0;
         end
         ev[m] = bq[m].size() != 0;
         er = rrst_n && !rempty[m] &&
              (bq[m].size() + fq[m].size() - int'(ev[m] && m_ready) < 2);
         chk("m_valid", m, int'(m_valid[m]), int'(ev[m]));
         chk("rinc", m, int'(rinc[m]), int'(er));
         chk("pop_count", m, int'(pop_count[m]), int'(pc[m]));
         chk("count", m, dcnt[m], bq[m].size());
         chk("underflow", m, int'(rinc[m] && rempty[m]), 0);
         if (ev[m])
            chk("m_data", m, int'(m_data[m]), int'(bq[m][0]));
         dr[m] = ev[m] && m_ready;
         po[m] = rinc[m];
         if (rinc[m])
            rinc_cnt[m]++;
      end
      @(posedge rclk);
      #1;
      for (int m = 0; m < 2; m++) begin
         if (dr[m]) begin
            void'(bq[m].pop_front());
            pc[m]++;
         end
         if (fq[m].size() != 0)
            bq[m].push_back(fq[m].pop_front());
         if (po[m] && q[m].size() != 0) begin
            w = q[m].pop_front();
            if (m == 0)
               bq[m].push_back(w);
            else begin
               fq[m].push_back(w);
               rdata[1] = w;
            end
         end
         rempty[m] = (q[m].size() == 0) || gate[m];
      end
      rdata[0] = (q[0].size() != 0) ? q[0][0] : 8'h00;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fall [2], first [2], last [2], run [2], fd [2], ld [2], r0 [2];
      int pushed [2], need [2], nxt [2], seen [2];
      repeat (3) @(posedge rclk);
      #2;
      for (int m = 0; m < 2; m++) begin
         chk("reset m_valid", m, int'(m_valid[m]), 0);
         chk("reset pop_count", m, int'(pop_count[m]), 0);
         chk("reset m_data", m, int'(m_data[m]), 0);
         chk("reset rinc", m, int'(rinc[m]), 0);
      end
      rrst_n = 1'b1;
      cyc(2);

      // preload 0x01..0x10 and stream
      for (int i = 1; i <= 16; i++) begin
         q[0].push_back(8'(i));
         q[1].push_back(8'(i));
      end
      m_ready = 1'b1;
      fall = '{-1, -1};
      first = '{-1, -1};
      last = '{-1, -1};
      run = '{0, 0};
      fd = '{0, 0};
      ld = '{0, 0};
      for (int c = 0; c < 40; c++) begin
         @(negedge rclk);
         for (int m = 0; m < 2; m++) begin
            if (fall[m] < 0 && !rempty[m])
               fall[m] = c;
            if (m_valid[m]) begin
               if (first[m] < 0) begin
                  first[m] = c;
                  fd[m] = int'(m_data[m]);
               end
               run[m]++;
               last[m] = c;
               ld[m] = int'(m_data[m]);
            end
         end
      end
      for (int m = 0; m < 2; m++) begin
         chk("first latency", m, first[m] - fall[m], (m == 0) ? 1 : 2);
         chk("valid cycles", m, run[m], 16);
         chk("contiguous", m, last[m] - first[m], 15);
         chk("first word", m, fd[m], 8'h01);
         chk("last word", m, ld[m], 8'h10);
         chk("stream pop_count", m, int'(pop_count[m]), 16);
      end
      cyc(1);

      // back-pressure: exactly two pops fill the buffer, head holds
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         q[0].push_back(8'(8'hA0 + i));
         q[1].push_back(8'(8'hA0 + i));
      end
      r0 = rinc_cnt;
      cyc(10);
      for (int m = 0; m < 2; m++) begin
         chk("stall rinc pulses", m, rinc_cnt[m] - r0[m], 2);
         chk("stall count", m, dcnt[m], 2);
         chk("stall m_data", m, int'(m_data[m]), 8'hA0);
         chk("stall rinc low", m, int'(rinc[m]), 0);
      end
      drain_wait("stall drain");

      // random ready, random rempty gating on the registered-read instance
      pushed = '{0, 0};
      for (int c = 0; c < 20000 && (pushed[0] < 1000 || pushed[1] < 1000); c++) begin
         m_ready = 1'($urandom_range(0, 1));
         gate[1] = 1'($urandom_range(0, 1));
         for (int m = 0; m < 2; m++)
            if (pushed[m] < 1000 && q[m].size() < 3) begin
               q[m].push_back(8'($urandom));
               pushed[m]++;
            end
         cyc(1);
      end
      chk("random pushed", 0, pushed[0], 1000);
      chk("random pushed", 1, pushed[1], 1000);
      drain_wait("random drain");

      // reset mid-transfer with a full buffer and a word in flight
      for (int i = 0; i < 8; i++) begin
         q[0].push_back(8'(8'hC0 + i));
         q[1].push_back(8'(8'hC0 + i));
      end
      m_ready = 1'b0;
      cyc(4);
      m_ready = 1'b1;
      cyc(1);
      rrst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("async rst m_valid", m, int'(m_valid[m]), 0);
         chk("async rst pop_count", m, int'(pop_count[m]), 0);
         chk("async rst m_data", m, int'(m_data[m]), 0);
         chk("async rst rinc", m, int'(rinc[m]), 0);
      end
      cyc(2);
      for (int m = 0; m < 2; m++)
         nxt[m] = (q[m].size() != 0) ? int'(q[m][0]) : -1;
      rrst_n = 1'b1;
      seen = '{0, 0};
      for (int c = 0; c < 20; c++) begin
         @(negedge rclk);
         for (int m = 0; m < 2; m++)
            if (seen[m] == 0 && m_valid[m]) begin
               chk("word after reset", m, int'(m_data[m]), nxt[m]);
               seen[m] = 1;
            end
      end
      chk("delivered after reset", 0, seen[0], 1);
      chk("delivered after reset", 1, seen[1], 1);
      drain_wait("reset drain");

      // pop_count wrap
      for (int m = 0; m < 2; m++) begin
         need[m] = 65535 - int'(pc[m]);
         pushed[m] = 0;
      end
      for (int c = 0; c < 70000 && !(pc[0] == 16'hFFFF && pc[1] == 16'hFFFF); c++) begin
         for (int m = 0; m < 2; m++)
            if (pushed[m] < need[m]) begin
               q[m].push_back(8'($urandom));
               pushed[m]++;
            end
         cyc(1);
      end
      cyc(2);
      for (int m = 0; m < 2; m++) begin
         chk("pop_count max", m, int'(pop_count[m]), 16'hFFFF);
         q[m].push_back(8'h5A);
      end
      cyc(6);
      for (int m = 0; m < 2; m++)
         chk("pop_count wrap", m, int'(pop_count[m]), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
